// File: rtl/instr_encoder.sv
// Purpose: packs decoded RV32I fields into a legal instruction word, tags it with an IMEM byte address.
// Latency: a request accepted in cycle N is at the queue head in cycle N+1 when the queue is empty.
// Backpressure: 2-entry output queue; in_ready is low only when both entries are full.
module instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [3:0]        alu_op,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_illegal,
   output logic [15:0]       n_illegal
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [2:0] FMT_R      = 3'd0;
   localparam logic [2:0] FMT_I      = 3'd1;
   localparam logic [2:0] FMT_LOAD   = 3'd2;
   localparam logic [2:0] FMT_STORE  = 3'd3;
   localparam logic [2:0] FMT_BRANCH = 3'd4;
   localparam logic [2:0] FMT_JAL    = 3'd5;
   localparam logic [2:0] FMT_LUI    = 3'd6;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_XOR = 4'h2;
   localparam logic [3:0] ALU_OR  = 4'h3;
   localparam logic [3:0] ALU_AND = 4'h4;
   localparam logic [3:0] ALU_SLL = 4'h5;
   localparam logic [3:0] ALU_SRL = 4'h6;
   localparam logic [3:0] ALU_BEQ = 4'h7;
   localparam logic [3:0] ALU_BNE = 4'h8;
   localparam logic [3:0] ALU_SLT = 4'h9;
   localparam logic [3:0] ALU_SRA = 4'hA;
   localparam logic [3:0] ALU_BLT = 4'hC;
   localparam logic [3:0] ALU_BGE = 4'hD;

   logic [2:0]  alu_f3;
   logic        alu_alt;
   logic        alu_ok;
   logic        alu_shift;
   logic [2:0]  br_f3;
   logic        br_ok;
   logic [6:0]  funct7;
   logic        imm12_ok, imm13_ok, imm21_ok, shamt_ok, upper_ok;
   logic [31:0] enc_word;
   logic        enc_bad;

   logic [1:0]  count;
   logic [31:0] head_instr, tail_instr;
   logic        head_ill, tail_ill;
   logic        do_push, do_pop;

   // Range checks: a value fits a signed N-bit field when all bits above N-1 copy its sign bit.
   assign imm12_ok = (imm[31:11] == {21{imm[11]}});
   assign imm13_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
   assign imm21_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
   assign shamt_ok = (imm[31:5] == 27'd0);
   assign upper_ok = (imm[11:0] == 12'd0);
   assign funct7   = alu_alt ? 7'h20 : 7'h00;

   // Map the ALU_ctrl code onto ALU funct3/funct7 and branch funct3, flagging codes with no mapping.
   always_comb begin
      alu_f3    = 3'd0;
      alu_alt   = 1'b0;
      alu_ok    = 1'b1;
      alu_shift = 1'b0;
      case (alu_op)
         ALU_ADD: alu_f3 = 3'd0;
         ALU_SUB: begin alu_f3 = 3'd0; alu_alt = 1'b1; end
         ALU_SLL: begin alu_f3 = 3'd1; alu_shift = 1'b1; end
         ALU_SLT: alu_f3 = 3'd2;
         ALU_XOR: alu_f3 = 3'd4;
         ALU_SRL: begin alu_f3 = 3'd5; alu_shift = 1'b1; end
         ALU_SRA: begin alu_f3 = 3'd5; alu_shift = 1'b1; alu_alt = 1'b1; end
         ALU_OR:  alu_f3 = 3'd6;
         ALU_AND: alu_f3 = 3'd7;
         default: alu_ok = 1'b0;
      endcase
      br_f3 = 3'd0;
      br_ok = 1'b1;
      case (alu_op)
         ALU_BEQ: br_f3 = 3'd0;
         ALU_BNE: br_f3 = 3'd1;
         ALU_BLT: br_f3 = 3'd4;
         ALU_BGE: br_f3 = 3'd5;
         default: br_ok = 1'b0;
      endcase
   end

   // Assemble the word for the requested format; any illegal combination collapses to a NOP.
   always_comb begin
      enc_word = NOP;
      enc_bad  = 1'b0;
      case (fmt)
         FMT_R: begin
            enc_word = {funct7, rs2, rs1, alu_f3, rd, 7'b0110011};
            enc_bad  = !alu_ok;
         end
         FMT_I: begin
            if (alu_shift) begin
               enc_word = {funct7, imm[4:0], rs1, alu_f3, rd, 7'b0010011};
               enc_bad  = !shamt_ok;
            end else begin
               enc_word = {imm[11:0], rs1, alu_f3, rd, 7'b0010011};
               enc_bad  = !alu_ok || (alu_op == ALU_SUB) || !imm12_ok;
            end
         end
         FMT_LOAD: begin
            enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            enc_bad  = (alu_op != ALU_ADD) || !imm12_ok;
         end
         FMT_STORE: begin
            enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            enc_bad  = (alu_op != ALU_ADD) || !imm12_ok;
         end
         FMT_BRANCH: begin
            enc_word = {imm[12], imm[10:5], rs2, rs1, br_f3, imm[4:1], imm[11], 7'b1100011};
            enc_bad  = !br_ok || !imm13_ok;
         end
         FMT_JAL: begin
            // alu_op carries no meaning for JAL and is not checked
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            enc_bad  = !imm21_ok;
         end
         FMT_LUI: begin
            enc_word = {imm[31:12], rd, 7'b0110111};
            enc_bad  = !upper_ok;
         end
         default: begin
            enc_word = {imm[31:12], rd, 7'b0010111};
            enc_bad  = !upper_ok;
         end
      endcase
      if (enc_bad) enc_word = NOP;
   end

   // in_ready depends only on registered occupancy, never on out_ready in the same cycle.
   assign in_ready    = (count != 2'd2);
   assign out_valid   = (count != 2'd0);
   assign out_instr   = head_instr;
   assign out_illegal = head_ill;
   assign do_push     = in_valid && in_ready;
   assign do_pop      = out_valid && out_ready;

   // Two-entry FIFO, IMEM address counter and saturating illegal-request counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count      <= 2'd0;
         head_instr <= 32'd0;
         head_ill   <= 1'b0;
         tail_instr <= 32'd0;
         tail_ill   <= 1'b0;
         out_addr   <= BASE_ADDR;
         n_illegal  <= 16'd0;
      end else begin
         if (do_push && do_pop) begin
            // only possible with one entry held: the new word replaces the departing head
            head_instr <= enc_word;
            head_ill   <= enc_bad;
         end else if (do_push) begin
            if (count == 2'd0) begin
               head_instr <= enc_word;
               head_ill   <= enc_bad;
            end else begin
               tail_instr <= enc_word;
               tail_ill   <= enc_bad;
            end
            count <= count + 2'd1;
         end else if (do_pop) begin
            head_instr <= tail_instr;
            head_ill   <= tail_ill;
            count      <= count - 2'd1;
         end
         if (do_pop) out_addr <= out_addr + ADDR_W'(4);
         if (do_push && enc_bad && (n_illegal != 16'hFFFF)) n_illegal <= n_illegal + 16'd1;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: random and directed requests, scoreboard queue checked by a monitor.
// Expected words come from an integer-range reference model of the RV32I packing rules.
// Output consumer readiness is randomised to exercise queue backpressure.
module tb_instr_encoder;

   localparam int          ADDR_W = 32;
   localparam logic [31:0] BASE   = 32'h0;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        fmt;
   logic [3:0]        alu_op;
   logic [4:0]        rd, rs1, rs2;
   logic [31:0]       imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              out_illegal;
   logic [15:0]       n_illegal;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .out_illegal(out_illegal), .n_illegal(n_illegal)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic        ill;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_addr   = BASE;
   int          nill_model = 0;
   int          n_tests    = 0;
   int          n_fail     = 0;
   bit          rand_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: legality from integer ranges, then field placement of the RV32I formats.
   function automatic void ref_encode(input logic [2:0] f, input logic [3:0] op,
                                      input logic [4:0] d, input logic [4:0] s1,
                                      input logic [4:0] s2, input logic [31:0] im,
                                      output logic [31:0] w, output logic bad);
      int         v;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       ok, shift, bok;
      logic [2:0] bf3;
      v = $signed(im);
      ok = 1'b1; shift = 1'b0; f3 = 3'd0; f7 = 7'h00;
      case (op)
         4'h0: f3 = 3'd0;
         4'h1: begin f3 = 3'd0; f7 = 7'h20; end
         4'h2: f3 = 3'd4;
         4'h3: f3 = 3'd6;
         4'h4: f3 = 3'd7;
         4'h5: begin f3 = 3'd1; shift = 1'b1; end
         4'h6: begin f3 = 3'd5; shift = 1'b1; end
         4'hA: begin f3 = 3'd5; shift = 1'b1; f7 = 7'h20; end
         4'h9: f3 = 3'd2;
         default: ok = 1'b0;
      endcase
      bok = 1'b1; bf3 = 3'd0;
      case (op)
         4'h7: bf3 = 3'd0;
         4'h8: bf3 = 3'd1;
         4'hC: bf3 = 3'd4;
         4'hD: bf3 = 3'd5;
         default: bok = 1'b0;
      endcase
      bad = 1'b0;
      w   = 32'h13;
      case (f)
         3'd0: begin bad = !ok; w = {f7, s2, s1, f3, d, 7'h33}; end
         3'd1: begin
            if (!ok || op == 4'h1) bad = 1'b1;
            else if (shift) begin
               bad = (v < 0) || (v > 31);
               w   = {f7, im[4:0], s1, f3, d, 7'h13};
            end else begin
               bad = (v < -2048) || (v > 2047);
               w   = {im[11:0], s1, f3, d, 7'h13};
            end
         end
         3'd2: begin bad = (op != 4'h0) || (v < -2048) || (v > 2047); w = {im[11:0], s1, 3'd2, d, 7'h03}; end
         3'd3: begin bad = (op != 4'h0) || (v < -2048) || (v > 2047); w = {im[11:5], s2, s1, 3'd2, im[4:0], 7'h23}; end
         3'd4: begin
            bad = !bok || (v < -4096) || (v > 4095) || im[0];
            w   = {im[12], im[10:5], s2, s1, bf3, im[4:1], im[11], 7'h63};
         end
         3'd5: begin
            bad = (v < -1048576) || (v > 1048575) || im[0];
            w   = {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
         end
         3'd6: begin bad = ((im & 32'hFFF) != 0); w = {im[31:12], d, 7'h37}; end
         default: begin bad = ((im & 32'hFFF) != 0); w = {im[31:12], d, 7'h17}; end
      endcase
      if (bad) w = 32'h13;
   endfunction

   function automatic logic [31:0] pick_imm();
      logic [31:0] t;
      t = $urandom;
      case ($urandom_range(0, 4))
         0: ;
         1: case ($urandom_range(0, 9))
               0: t = 32'd2047;      1: t = 32'd2048;      2: t = 32'hFFFFF800;
               3: t = 32'hFFFFF7FF;  4: t = 32'd4094;      5: t = 32'd4096;
               6: t = 32'hFFFFF000;  7: t = 32'h000FFFFE;  8: t = 32'h00100000;
               default: t = 32'hFFF00000;
            endcase
         2: t = 32'($urandom_range(0, 64)) - 32'd32;
         3: t = {t[31:12], 12'h000};
         default: t = 32'($urandom_range(0, 40));
      endcase
      return t;
   endfunction

   // Capture: every accepted request pushes its model response; also tracks the illegal count.
   always @(negedge clk) begin : capture
      logic [31:0] w;
      logic        bad;
      if (!reset) nill_model = 0;
      else begin
         check("n_illegal", 32'(n_illegal), 32'(nill_model));
         if (in_valid && in_ready) begin
            ref_encode(fmt, alu_op, rd, rs1, rs2, imm, w, bad);
            exp_q.push_back('{instr: w, ill: bad});
            if (bad && nill_model < 65535) nill_model++;
         end
      end
   end

   // Monitor: every word the consumer takes is compared against the oldest expected entry.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         exp_q.delete();
         exp_addr = BASE;
      end else if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got word %h, expected no output", out_instr);
         end else begin
            e = exp_q.pop_front();
            check("out_instr", out_instr, e.instr);
            check("out_illegal", 32'(out_illegal), 32'(e.ill));
            check("out_addr", out_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
         end
      end
   end

   task automatic send(input logic [2:0] f, input logic [3:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
      fmt = f; alu_op = op; rd = d; rs1 = s1; rs2 = s2; imm = im;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            return;
         end
         @(posedge clk); #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected acceptance");
      in_valid = 1'b0;
   endtask

   task automatic drain();
      @(posedge clk); #1 out_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) begin
            @(posedge clk); #1 out_ready = 1'b0;
            return;
         end
      end
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words outstanding, expected 0", exp_q.size());
      out_ready = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      @(negedge clk);
      @(posedge clk); #1 reset = 1'b1;
   endtask

   task automatic directed(input string name, input logic [2:0] f, input logic [3:0] op,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] im, input logic [31:0] ew, input logic eill);
      out_ready = 1'b0;
      send(f, op, d, s1, s2, im);
      @(negedge clk);
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_word"}, out_instr, ew);
      check({name, "_ill"}, 32'(out_illegal), 32'(eill));
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
   endtask

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [2:0] rf;
      logic [3:0] rop;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      fmt = 3'd0; alu_op = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_illegal", 32'(out_illegal), 32'd0);
      check("rst_out_addr", out_addr, BASE);
      check("rst_n_illegal", 32'(n_illegal), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      directed("add",    3'd0, 4'h0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3, 1'b0);
      directed("sub",    3'd0, 4'h1, 5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3, 1'b0);
      directed("addi_m1",3'd1, 4'h0, 5'd1, 5'd0, 5'd9, 32'hFFFFFFFF,   32'hFFF00093, 1'b0);
      directed("addi_big",3'd1,4'h0, 5'd1, 5'd0, 5'd0, 32'd2048,       32'h00000013, 1'b1);
      check("n_illegal_one", 32'(n_illegal), 32'd1);
      directed("beq8",   3'd4, 4'h7, 5'd9, 5'd1, 5'd2, 32'd8,          32'h00208463, 1'b0);
      directed("beq7",   3'd4, 4'h7, 5'd0, 5'd1, 5'd2, 32'd7,          32'h00000013, 1'b1);
      directed("lui",    3'd6, 4'h3, 5'd5, 5'd7, 5'd8, 32'h12345000,   32'h123452B7, 1'b0);
      directed("auipc",  3'd7, 4'h3, 5'd5, 5'd7, 5'd8, 32'h12345000,   32'h12345297, 1'b0);
      check("n_illegal_two", 32'(n_illegal), 32'd2);

      // Backpressure: three back-to-back requests with the consumer stalled.
      apply_reset();
      fmt = 3'd0; alu_op = 4'h0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = 32'd0;
      in_valid = 1'b1;
      @(negedge clk); check("bp_rdy_empty", 32'(in_ready), 32'd1);
      @(posedge clk); #1 alu_op = 4'h1;
      @(negedge clk); check("bp_rdy_one", 32'(in_ready), 32'd1);
      @(posedge clk); #1 fmt = 3'd6; rd = 5'd5; imm = 32'h12345000;
      @(negedge clk); check("bp_rdy_full", 32'(in_ready), 32'd0);
      @(posedge clk); #1 out_ready = 1'b1;
      #1 check("bp_no_comb_path", 32'(in_ready), 32'd0);
      @(negedge clk);
      @(negedge clk); check("bp_rdy_again", 32'(in_ready), 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      drain();
      check("bp_final_addr", out_addr, BASE + 32'd12);

      // Random traffic with a randomly stalling consumer.
      rand_ready = 1'b1;
      for (int k = 0; k < 400; k++) begin
         rf  = 3'($urandom_range(0, 7));
         rop = 4'($urandom_range(0, 15));
         if ((rf == 3'd2 || rf == 3'd3) && $urandom_range(0, 1) == 1) rop = 4'h0;
         if (rf == 3'd5) rop = 4'h0;
         send(rf, rop, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), pick_imm());
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
         end
      end
      rand_ready = 1'b0;
      drain();

      // Reset with two words queued.
      out_ready = 1'b0;
      send(3'd1, 4'h0, 5'd2, 5'd3, 5'd0, 32'd4096);
      send(3'd0, 4'h4, 5'd2, 5'd3, 5'd4, 32'd0);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      check("pre_rst_rdy", 32'(in_ready), 32'd0);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_addr", out_addr, BASE);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_instr", out_instr, 32'd0);
      check("mid_rst_n_illegal", 32'(n_illegal), 32'd0);
      @(negedge clk);
      @(posedge clk); #1 reset = 1'b1;
      directed("post_rst_xor", 3'd0, 4'h2, 5'd4, 5'd5, 5'd6, 32'd0, 32'h0062C233, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
